bp_cce_hybrid_req_arbiter: RTL

//  Merges two LCE request BedRock burst streams into the single CCE request

---
 rtl/bp_cce_hybrid_req_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bp_cce_hybrid_req_arbiter.sv
// Hybrid CCE request arbiter.
//
// Merges two LCE request BedRock burst streams (pending-queue replays and new
// network requests) into the single CCE request input. Pending requests win
// arbitration unless the new source has waited starve_limit_p consecutive
// pending grants. A source is locked for a whole message, from header through
// the data beat marked last.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   pend_*                  pending-queue source (header/has_data/data/last, valid->yumi)
//   new_*                   new-request source (same signal set)
//   header_o .. last_o      merged BedRock burst output (valid/ready)
//   grant_pend_o            selected (e_ready) or locked (e_data) source is pending
//   busy_o                  a data burst is locked
module bp_cce_hybrid_req_arbiter #(
    parameter int unsigned header_width_p = 64,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [header_width_p-1:0] pend_header_i,
    input  logic                      pend_header_v_i,
    output logic                      pend_header_yumi_o,
    input  logic                      pend_has_data_i,
    input  logic [data_width_p-1:0]   pend_data_i,
    input  logic                      pend_data_v_i,
    output logic                      pend_data_yumi_o,
    input  logic                      pend_last_i,

    input  logic [header_width_p-1:0] new_header_i,
    input  logic                      new_header_v_i,
    output logic                      new_header_yumi_o,
    input  logic                      new_has_data_i,
    input  logic [data_width_p-1:0]   new_data_i,
    input  logic                      new_data_v_i,
    output logic                      new_data_yumi_o,
    input  logic                      new_last_i,

    output logic [header_width_p-1:0] header_o,
    output logic                      header_v_o,
    input  logic                      header_ready_and_i,
    output logic                      has_data_o,
    output logic [data_width_p-1:0]   data_o,
    output logic                      data_v_o,
    input  logic                      data_ready_and_i,
    output logic                      last_o,

    output logic                      grant_pend_o,
    output logic                      busy_o
);

    localparam int unsigned cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

    typedef enum logic {e_ready, e_data} state_e;

    state_e                  state_q, state_d;
    logic                    lock_pend_q, lock_pend_d;
    logic [cnt_width_lp-1:0] starve_cnt_q, starve_cnt_d;

    logic sel_pend;
    logic hdr_hs;
    logic data_hs;

    // Pending wins unless new is waiting and has already been passed over
    // starve_limit_p times in a row.
    assign sel_pend = pend_header_v_i
                      & ~(new_header_v_i & (starve_cnt_q == starve_limit_lp));

    always_comb begin
        state_d            = state_q;
        lock_pend_d        = lock_pend_q;
        starve_cnt_d       = starve_cnt_q;
        header_v_o         = 1'b0;
        pend_header_yumi_o = 1'b0;
        new_header_yumi_o  = 1'b0;
        data_v_o           = 1'b0;
        pend_data_yumi_o   = 1'b0;
        new_data_yumi_o    = 1'b0;
        grant_pend_o       = 1'b0;
        busy_o             = 1'b0;
        hdr_hs             = 1'b0;
        data_hs            = 1'b0;

        // Payload muxes are don't-care while the matching valid is low.
        header_o   = sel_pend ? pend_header_i : new_header_i;
        has_data_o = sel_pend ? pend_has_data_i : new_has_data_i;
        data_o     = lock_pend_q ? pend_data_i : new_data_i;
        last_o     = lock_pend_q ? pend_last_i : new_last_i;

        // Outputs are gated by reset so they drop the moment reset asserts.
        if (reset_n_i) begin
            case (state_q)
                e_ready: begin
                    grant_pend_o       = sel_pend;
                    header_v_o         = sel_pend ? pend_header_v_i : new_header_v_i;
                    hdr_hs             = header_v_o & header_ready_and_i;
                    pend_header_yumi_o = hdr_hs & sel_pend;
                    new_header_yumi_o  = hdr_hs & ~sel_pend;
                    if (hdr_hs && has_data_o) begin
                        state_d     = e_data;
                        lock_pend_d = sel_pend;
                    end
                end
                e_data: begin
                    busy_o           = 1'b1;
                    grant_pend_o     = lock_pend_q;
                    data_v_o         = lock_pend_q ? pend_data_v_i : new_data_v_i;
                    data_hs          = data_v_o & data_ready_and_i;
                    pend_data_yumi_o = data_hs & lock_pend_q;
                    new_data_yumi_o  = data_hs & ~lock_pend_q;
                    if (data_hs && last_o) begin
                        state_d = e_ready;
                    end
                end
                default: state_d = e_ready;
            endcase
        end

        // Count consecutive pending grants taken while new was waiting.
        if (!new_header_v_i || new_header_yumi_o) begin
            starve_cnt_d = '0;
        end else if (pend_header_yumi_o && (starve_cnt_q != starve_limit_lp)) begin
            starve_cnt_d = starve_cnt_q + cnt_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_ready;
            lock_pend_q  <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_pend_q  <= lock_pend_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
